// File: rtl/reg_exec_seq.sv
// reg_exec_seq: three-cycle instruction sequencer in front of an 8x8 register file.
// An instruction is accepted in IDLE, its operands are read in READ, and the
// result is written back in WB. Zero and carry flags are kept here.
// Optional build macro SEQ_SHIFT_OPS_EN adds SHL (opcode 8) and SHR (opcode 9);
// when it is not defined those opcodes are illegal and no shifter is built.
module reg_exec_seq #(
   parameter int ILLEGAL_AS_NOP = 1,
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [ADDR_W-1:0] rf_read_reg1,
   output logic [ADDR_W-1:0] rf_read_reg2,
   input  logic [DATA_W-1:0] rf_read_data1,
   input  logic [DATA_W-1:0] rf_read_data2,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              done,
   output logic              illegal,
   output logic              halted
);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDI = 4'd1;
   localparam logic [3:0] OP_MOV = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
`ifdef SEQ_SHIFT_OPS_EN
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
`endif

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WB, S_HALT} state_t;

   state_t            state;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] imm_q;

   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              alu_wr;
   logic              alu_ill;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;

   // ALU: result, next carry (defaults to the current one), write/illegal decode
   always_comb begin
      alu_res   = '0;
      alu_carry = flag_carry;
      alu_wr    = 1'b0;
      alu_ill   = 1'b0;
      sum       = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
      // the ninth bit of a widened subtraction is the borrow (rs1 < rs2)
      diff      = {1'b0, rf_read_data1} - {1'b0, rf_read_data2};
      case (op_q)
         OP_NOP: ;
         OP_LDI: begin alu_res = imm_q;         alu_wr = 1'b1; end
         OP_MOV: begin alu_res = rf_read_data1; alu_wr = 1'b1; end
         OP_ADD: begin
            alu_res = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; alu_wr = 1'b1;
         end
         OP_SUB: begin
            alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; alu_wr = 1'b1;
         end
         OP_AND: begin
            alu_res = rf_read_data1 & rf_read_data2; alu_carry = 1'b0; alu_wr = 1'b1;
         end
         OP_OR: begin
            alu_res = rf_read_data1 | rf_read_data2; alu_carry = 1'b0; alu_wr = 1'b1;
         end
         OP_XOR: begin
            alu_res = rf_read_data1 ^ rf_read_data2; alu_carry = 1'b0; alu_wr = 1'b1;
         end
`ifdef SEQ_SHIFT_OPS_EN
         OP_SHL: begin
            alu_res   = {rf_read_data1[DATA_W-2:0], 1'b0};
            alu_carry = rf_read_data1[DATA_W-1];
            alu_wr    = 1'b1;
         end
         OP_SHR: begin
            alu_res   = {1'b0, rf_read_data1[DATA_W-1:1]};
            alu_carry = rf_read_data1[0];
            alu_wr    = 1'b1;
         end
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         op_q          <= '0;
         rd_q          <= '0;
         imm_q         <= '0;
         instr_ready   <= 1'b1;
         rf_read_reg1  <= '0;
         rf_read_reg2  <= '0;
         rf_reg_write  <= 1'b0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
         flag_zero     <= 1'b0;
         flag_carry    <= 1'b0;
         done          <= 1'b0;
         illegal       <= 1'b0;
         halted        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  op_q         <= instr[15:12];
                  rd_q         <= instr[11:9];
                  imm_q        <= instr[7:0];
                  rf_read_reg1 <= instr[8:6];
                  rf_read_reg2 <= instr[5:3];
                  instr_ready  <= 1'b0;
                  state        <= S_READ;
               end
            end
            S_READ: begin
               rf_write_data <= alu_res;
               rf_write_reg  <= rd_q;
               rf_reg_write  <= alu_wr;
               if (alu_wr) flag_zero <= (alu_res == '0);
               flag_carry    <= alu_carry;
               done          <= 1'b1;
               illegal       <= alu_ill;
               state         <= S_WB;
            end
            S_WB: begin
               rf_reg_write <= 1'b0;
               done         <= 1'b0;
               illegal      <= 1'b0;
               if (illegal && ILLEGAL_AS_NOP == 0) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  instr_ready <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: ; // HALT: only reset leaves
         endcase
      end
   end

endmodule

// File: tb/tb_reg_exec_seq.sv
// Randomised and directed bench for reg_exec_seq with a register-file model,
// a reference model of the ISA, and a scoreboard checked on every done pulse.
module tb_reg_exec_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [2:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
   logic [7:0]  rf_read_data1, rf_read_data2, rf_write_data;
   logic        rf_reg_write, flag_zero, flag_carry, done, illegal, halted;

   // second instance with halting on illegal opcodes
   logic        h_rst = 1'b1;
   logic        h_valid = 1'b0;
   logic        h_ready;
   logic [15:0] h_instr = 16'hF000;
   logic [2:0]  h_rr1, h_rr2, h_wr;
   logic [7:0]  h_rd1 = 8'h00, h_rd2 = 8'h00, h_wd;
   logic        h_we, h_z, h_c, h_done, h_ill, h_halted;

   always #5 clk = ~clk;

   reg_exec_seq #(.ILLEGAL_AS_NOP(1)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg),
      .rf_write_data(rf_write_data), .flag_zero(flag_zero), .flag_carry(flag_carry),
      .done(done), .illegal(illegal), .halted(halted));

   reg_exec_seq #(.ILLEGAL_AS_NOP(0)) dut_h (
      .clk(clk), .rst(h_rst), .instr_valid(h_valid), .instr_ready(h_ready),
      .instr(h_instr), .rf_read_reg1(h_rr1), .rf_read_reg2(h_rr2),
      .rf_read_data1(h_rd1), .rf_read_data2(h_rd2),
      .rf_reg_write(h_we), .rf_write_reg(h_wr),
      .rf_write_data(h_wd), .flag_zero(h_z), .flag_carry(h_c),
      .done(h_done), .illegal(h_ill), .halted(h_halted));

   // register file environment: async read, sync write, reset wins over write
   logic [7:0] rf [8];
   assign rf_read_data1 = rf[rf_read_reg1];
   assign rf_read_data2 = rf[rf_read_reg2];
   always @(posedge clk) begin
      if (rst) for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      else if (rf_reg_write) rf[rf_write_reg] <= rf_write_data;
   end

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, n_acc = 0, n_sent = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model: architectural registers and flags
   int m_regs [8];
   bit mz = 0, mc = 0;
   logic [15:0] q [$];

   // expectation packed as {ill, wr, zero, carry, rd[2:0], data[7:0]}
   function automatic logic [15:0] model(input logic [15:0] ins);
      int op = int'(ins[15:12]);
      int rd = int'(ins[11:9]);
      int a  = m_regs[ins[8:6]];
      int b  = m_regs[ins[5:3]];
      int r  = 0;
      bit wr = 1, ill = 0;
      case (op)
         0: wr = 0;
         1: r = int'(ins[7:0]);
         2: r = a;
         3: begin r = (a + b) % 256; mc = (a + b) > 255; end
         4: begin r = (a - b + 256) % 256; mc = a < b; end
         5: begin r = a & b; mc = 0; end
         6: begin r = a | b; mc = 0; end
         7: begin r = a ^ b; mc = 0; end
`ifdef SEQ_SHIFT_OPS_EN
         8: begin r = (a * 2) % 256; mc = a >= 128; end
         9: begin r = a / 2; mc = (a % 2) == 1; end
`endif
         default: begin wr = 0; ill = 1; end
      endcase
      if (wr) begin
         m_regs[rd] = r;
         mz = (r == 0);
         return {4'b0, ill, 1'b1, mz, mc, 3'(rd), 8'(r)};
      end
      return {4'b0, ill, 1'b0, mz, mc, 11'b0};
   endfunction

   // monitor: every retirement is checked against the head of the queue
   always @(negedge clk) begin
      logic [15:0] e, a;
      if (!rst && done) begin
         a = {4'b0, illegal, rf_reg_write, flag_zero, flag_carry,
              rf_reg_write ? rf_write_reg : 3'b0, rf_reg_write ? rf_write_data : 8'b0};
         if (q.size() == 0) chk("spurious_done", {16'b0, a}, 32'hFFFF_FFFF);
         else begin
            e = q.pop_front();
            chk("retire", {16'b0, a}, {16'b0, e});
         end
      end
      if (!rst && instr_valid && instr_ready) n_acc++;
   end

   int acc_cyc;

   // offer an instruction and wait for acceptance; keep leaves valid high
   task automatic send(input logic [15:0] ins, input bit keep);
      bit ok = 0;
      instr = ins;
      instr_valid = 1'b1;
      for (int k = 0; k < 10 && !ok; k++) begin
         @(negedge clk);
         if (instr_ready) ok = 1;
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
         instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      q.push_back(model(ins));
      n_sent++;
      #1;
      acc_cyc = cyc;
      if (!keep) instr_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clk);
      chk("drain", q.size(), 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int s1, input int s2);
      return {4'(op), 3'(rd), 3'(s1), 3'(s2), 3'b0};
   endfunction
   function automatic logic [15:0] ldi(input int rd, input int imm);
      return {4'h1, 3'(rd), 1'b0, 8'(imm)};
   endfunction

   int t0, t1;
   int accs [4];
   logic [7:0] keep_r7;

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      h_rst = 1'b0;
      chk("reset_state",
          {8'b0, instr_ready, rf_reg_write, rf_write_reg, rf_write_data, rf_read_reg1,
           rf_read_reg2, flag_zero, flag_carry, done, illegal, halted},
          {8'b0, 1'b1, 23'b0});

      // LDI/LDI/ADD with overflow to zero
      send(ldi(1, 8'h7F), 0); t0 = acc_cyc;
      send(ldi(2, 8'h81), 0); t1 = acc_cyc;
      chk("spacing_ldi", t1 - t0, 3);
      send(enc(3, 3, 1, 2), 0);
      chk("spacing_add", acc_cyc - t1, 3);
      drain();
      chk("add_r3", rf[3], 8'h00);
      chk("add_flags", {flag_zero, flag_carry}, 2'b11);

      // subtraction with and without borrow
      send(enc(4, 4, 1, 2), 0);
      drain();
      chk("sub_r4", rf[4], 8'hFE);
      chk("sub_flags", {flag_zero, flag_carry}, 2'b01);
      send(enc(4, 5, 2, 1), 0);
      drain();
      chk("sub_r5", rf[5], 8'h02);
      chk("sub_carry", flag_carry, 1'b0);

      // valid held high across four instructions, incl. rd==rs1==rs2
      send(enc(3, 6, 1, 1), 1); accs[0] = acc_cyc;
      send(enc(7, 6, 6, 6), 1); accs[1] = acc_cyc;
      send(enc(6, 0, 4, 5), 1); accs[2] = acc_cyc;
      send(enc(2, 7, 0, 0), 0); accs[3] = acc_cyc;
      for (int j = 1; j < 4; j++) chk("held_spacing", accs[j] - accs[j-1], 3);
      drain();

      // illegal opcode: no write, flags unchanged
      send(16'hF000 | 16'(enc(0, 2, 1, 1)), 0);
      drain();
      chk("illegal_flags", {flag_zero, flag_carry}, {mz, mc});
      chk("illegal_r2", rf[2], 8'h81);

      // shift opcodes (or their absence)
      send(ldi(1, 8'h81), 0);
`ifdef SEQ_SHIFT_OPS_EN
      send(enc(8, 7, 1, 0), 0);
      drain();
      chk("shl_r7", {rf[7], 7'b0, flag_carry}, {8'h02, 8'h01});
      send(enc(9, 7, 1, 0), 0);
      drain();
      chk("shr_r7", {rf[7], 7'b0, flag_carry}, {8'h40, 8'h01});
`else
      drain();
      keep_r7 = 8'(m_regs[7]);
      send(enc(8, 7, 1, 0), 0);
      drain();
      chk("op8_r7", rf[7], keep_r7);
`endif

      // reset during WB of LDI r6,0x55: no write, all outputs back to reset
      send(ldi(6, 8'h55), 0);
      @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      mz = 0; mc = 0;
      chk("rst_wb_r6", rf[6], 8'h00);
      chk("rst_wb_outputs",
          {8'b0, instr_ready, rf_reg_write, rf_write_reg, rf_write_data, rf_read_reg1,
           rf_read_reg2, flag_zero, flag_carry, done, illegal, halted},
          {8'b0, 1'b1, 23'b0});
      chk("rst_wb_queue", q.size(), 0);

      // random traffic with idle gaps and garbage on instr while not valid
      for (int i = 0; i < 200; i++) begin
         int op = $urandom_range(0, 15);
         logic [15:0] ins;
         bit keep = 1'($urandom_range(0, 1));
         if (op == 1) ins = ldi($urandom_range(0, 7), $urandom_range(0, 255));
         else ins = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7))
                    | 16'($urandom_range(0, 7));
         send(ins, keep);
         if (!keep) begin
            instr = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end
      instr_valid = 1'b0;
      drain();
      for (int i = 0; i < 8; i++) chk("final_reg", rf[i], 8'(m_regs[i]));
      chk("accept_count", n_acc, n_sent);

      // halting variant: illegal opcode stops the sequencer until reset
      h_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      h_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("halt_ill_pulse", {h_done, h_ill}, 2'b11);
      @(posedge clk); #1;
      chk("halt_state", {h_halted, h_ready}, 2'b10);
      h_valid = 1'b1;
      t0 = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (h_ready || !h_halted || h_done) t0++;
      end
      chk("halt_hold", t0, 0);
      h_valid = 1'b0;
      h_rst = 1'b1;
      @(posedge clk); #1;
      h_rst = 1'b0;
      chk("halt_cleared", {h_halted, h_ready, h_done, h_ill}, 4'b0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_exec_seq.md
Name: reg_exec_seq

Overview:
- Multi-cycle instruction sequencer that initiates all accesses to the 8x8-bit register file.
- Accepts 16-bit instructions over a valid/ready handshake and drives two asynchronous read-port addresses.
- Computes an 8-bit ALU result and issues one synchronous write-back per instruction.
- Sits between the instruction source (fetch stage or test driver) and the register file. Maintains zero/carry flags.

Parameters:
ILLEGAL_AS_NOP, 1, 1: illegal opcode behaves as NOP plus error pulse; 0: illegal opcode halts the sequencer until reset
DATA_W, 8, register/ALU data width; the ISA below requires 8
ADDR_W, 3, register address width; the ISA below requires 3

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept an instruction
instr  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LDI only)
rf_read_reg1  output  3  read port 1 address (rs1)
rf_read_reg2  output  3  read port 2 address (rs2)
rf_read_data1  input  8  register file read data 1 (asynchronous)
rf_read_data2  input  8  register file read data 2 (asynchronous)
rf_reg_write  output  1  write enable to register file
rf_write_reg  output  3  write address (rd)
rf_write_data  output  8  write data
flag_zero  output  1  last flag-updating result == 0
flag_carry  output  1  carry/borrow/shift-out of last arithmetic op
done  output  1  one-cycle pulse: instruction retired
illegal  output  1  one-cycle pulse: illegal opcode retired
halted  output  1  high while in HALT

Behaviour:
- Outputs are registered. Reset values:
  - state=IDLE, instr_ready=1, all rf_* outputs 0.
  - flag_zero=0, flag_carry=0, done=0, illegal=0, halted=0.
- States: IDLE, READ, WB, HALT.
- IDLE:
  - instr_ready=1.
  - On edge with instr_valid&instr_ready: latch opcode/rd/imm, load rf_read_reg1=rs1 and rf_read_reg2=rs2, set instr_ready=0, go to READ.
- READ (1 cycle):
  - Sample rf_read_data1/2 at the end edge and compute the result into rf_write_data.
  - rf_write_reg=rd. rf_reg_write=1 for writing opcodes.
  - Update flags, go to WB.
- WB (1 cycle):
  - rf_reg_write is high this cycle; the register file commits at the closing edge.
  - done=1 for this cycle (illegal=1 also, if applicable).
  - At the end edge: rf_reg_write=0, done=0, instr_ready=1, go to IDLE.
- Latency and throughput:
  - Accept edge E0 -> rf_reg_write high during cycle E1..E2 -> register updated at E2.
  - One instruction per 3 cycles.
  - Back-to-back: the next instruction is accepted at E3 and reads the value written at E2 (no hazard).
- Opcodes:
  - 0 NOP: no write, flags unchanged.
  - 1 LDI: rd<=imm; zero updated, carry unchanged.
  - 2 MOV: rd<=rs1; zero updated, carry unchanged.
  - 3 ADD: rd<=rs1+rs2 mod 256; carry=bit 8 of 9-bit sum.
  - 4 SUB: rd<=rs1-rs2 mod 256; carry=1 iff rs1<rs2 (borrow).
  - 5 AND, 6 OR, 7 XOR: bitwise; carry cleared.
  - 8..15: illegal unless enabled by the optional feature.
- zero is computed on the 8-bit result for every write-producing op.
- rd==rs1==rs2 is legal: operands are sampled before the write.
- Illegal opcode: no write, flags unchanged, illegal pulses with done in WB.
  - If ILLEGAL_AS_NOP=0: WB goes to HALT instead of IDLE.
  - HALT: instr_ready=0, halted=1; exits only on rst.
- instr_valid while instr_ready=0: ignored; the source holds instr until accepted. instr may change freely while instr_valid=0.
- rst in any state: all outputs return to reset values at that edge.
  - rst during the WB cycle: the register file's reset has priority, so no write occurs.
  - The in-flight instruction is discarded and the flags cleared.

Optional Feature:
- Macro SEQ_SHIFT_OPS_EN.
- Defined: opcode 8 SHL: rd<=rs1<<1, carry=rs1[7]. Opcode 9 SHR: rd<=rs1>>1 logical, carry=rs1[0]. zero updated for both.
- Undefined: opcodes 8 and 9 are illegal like 10..15. No shifter logic is synthesised.

Test Plan:
- Reset, then LDI r1,0x7F; LDI r2,0x81; ADD r3,r1,r2 -> r3=0x00, flag_zero=1, flag_carry=1; done pulses 3 times, 3 cycles apart.
- SUB r4,r1,r2 (0x7F-0x81) -> r4=0xFE, carry=1, zero=0; then SUB r5,r2,r1 -> r5=0x02, carry=0.
- Hold instr_valid high continuously with 4 instructions -> accepts at cycles 0,3,6,9 only; instr_ready low in READ/WB; no instruction dropped or duplicated.
- Opcode 0xF with ILLEGAL_AS_NOP=1 -> illegal+done pulse, registers and flags unchanged. With ILLEGAL_AS_NOP=0 -> halted=1, instr_ready stays 0 for 20 cycles, cleared by rst.
- Assert rst during the WB cycle of LDI r6,0x55 -> r6 remains 0x00, all outputs at reset values the next cycle, instr_ready=1.
- With SEQ_SHIFT_OPS_EN: r1=0x81, SHL r7,r1 -> r7=0x02, carry=1; SHR r7,r1 -> r7=0x40, carry=1. Without the macro: opcode 8 -> illegal pulse, r7 unchanged.
